// File: rtl/shape_processor_sched_pkg.sv
// Shared types for the shape processor SFR scheduler: FSM states, requester index
// and the control-word type carried unchanged to the processor.
package shape_processor_sched_pkg;

    localparam int MAX_REQ = 8;

    typedef logic [2:0] req_idx_t;

    // Same layout as the processor model's ctrl_sfr_reg; the scheduler treats it as opaque.
    typedef logic [31:0] ctrl_sfr_reg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        CHECK,
        RESP
    } sched_state_e;

endpackage

// File: rtl/shape_processor_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, searching upward with wrap.
module shape_processor_rr_arbiter
    import shape_processor_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] win,
    output req_idx_t           win_idx
);

    logic found;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
                win[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                win_idx = req_idx_t'((int'(ptr) + i) % NUM_REQ);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shape_processor_sfr_scheduler.sv
// Arbitrates NUM_REQ requesters onto the shape processor's single control-SFR bus.
// SHAPE_PROCESSOR_SCHED_READBACK_EN adds a read-back of the SFR after each write.
module shape_processor_sfr_scheduler
    import shape_processor_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0][31:0] req_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic                    resp_err,
    output logic [31:0]             resp_data,
    output logic                    busy,
    output logic                    write,
    output logic [31:0]             write_data,
    output logic                    read,
    input  logic [31:0]             read_data,
    input  logic                    error
);

    sched_state_e       state_q, state_d;
    req_idx_t           ptr_q, ptr_d, owner_q, owner_d, win_idx;
    logic [NUM_REQ-1:0] win, owner_oh_q, owner_oh_d;
    ctrl_sfr_reg        word_q, word_d, win_word;
    logic               err_q, err_d;

    shape_processor_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win[i]) win_word = req_data[i];
    end

`ifdef SHAPE_PROCESSOR_SCHED_READBACK_EN
    logic [31:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end
`else
    logic unused_read_data;
    assign unused_read_data = ^read_data;
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        word_d     = word_q;
        err_d      = err_q;
`ifdef SHAPE_PROCESSOR_SCHED_READBACK_EN
        data_d     = data_q;
`endif
        gnt        = '0;
        done       = '0;
        resp_err   = 1'b0;
        resp_data  = '0;
        write      = 1'b0;
        write_data = '0;
        read       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d    = win_idx;
                    owner_oh_d = win;
                    word_d     = win_word;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                write      = 1'b1;
                write_data = word_q;
                gnt        = owner_oh_q;
`ifdef SHAPE_PROCESSOR_SCHED_READBACK_EN
                state_d    = READ;
`else
                state_d    = CHECK;
`endif
            end
`ifdef SHAPE_PROCESSOR_SCHED_READBACK_EN
            // error answers the write, read_data the read, one cycle apart.
            READ: begin
                read    = 1'b1;
                err_d   = error;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = read_data;
                state_d = RESP;
            end
`else
            CHECK: begin
                err_d   = error;
                state_d = RESP;
            end
`endif
            RESP: begin
                done     = owner_oh_q;
                resp_err = err_q;
`ifdef SHAPE_PROCESSOR_SCHED_READBACK_EN
                resp_data = data_q;
`endif
                ptr_d   = (owner_q == req_idx_t'(NUM_REQ - 1)) ? '0 : owner_q + 3'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            owner_oh_q <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            word_q     <= word_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_shape_processor_sfr_scheduler.sv
// Self-checking bench for shape_processor_sfr_scheduler; adapts latencies to
// SHAPE_PROCESSOR_SCHED_READBACK_EN.
module tb_shape_processor_sfr_scheduler;

    localparam int N = 4;
`ifdef SHAPE_PROCESSOR_SCHED_READBACK_EN
    localparam bit RB   = 1'b1;
    localparam int DLAT = 4;
    localparam int PER  = 5;
`else
    localparam bit RB   = 1'b0;
    localparam int DLAT = 3;
    localparam int PER  = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0][31:0] req_data;
    logic [N-1:0]      gnt, done;
    logic              resp_err, busy, write, read, error;
    logic [31:0]       resp_data, write_data, read_data;

    shape_processor_sfr_scheduler #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .done       (done),
        .resp_err   (resp_err),
        .resp_data  (resp_data),
        .busy       (busy),
        .write      (write),
        .write_data (write_data),
        .read       (read),
        .read_data  (read_data),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         err;
        logic [31:0]  rdata;
        int           owner;
    } vec_t;

    typedef struct {
        logic [N-1:0] gnt;
        logic [31:0]  word;
        logic         err;
        logic [31:0]  data;
    } exp_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] g;
    } gexp_t;

    vec_t  vt[10];
    exp_t  sb[$];
    gexp_t gq[$];
    int    tests = 0;
    int    fails = 0;
    int    rd_cnt = 0;

    always @(negedge clk) if (read) rd_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: expected event did not occur", nm);
    endtask

    function automatic logic [31:0] wd(input int v, input int i);
        return 32'h5A00_0000 | (32'(v) << 8) | 32'(i);
    endfunction

    task automatic run_vec(input int vi);
        vec_t v;
        exp_t e;
        bit   got;
        v = vt[vi];
        @(negedge clk);
        chk($sformatf("v%0d_idle", vi), {31'b0, busy}, 32'h0);
        req = v.req;
        for (int i = 0; i < N; i++) req_data[i] = wd(vi, i);
        e.gnt = '0;
        e.gnt[v.owner] = 1'b1;
        e.word = wd(vi, v.owner);
        e.err  = v.err;
        e.data = RB ? v.rdata : 32'h0;
        sb.push_back(e);
        got = 1'b0;
        for (int c = 1; c <= DLAT + 3 && !got; c++) begin
            @(negedge clk);
            error     = (c == 2) ? v.err : 1'b0;
            read_data = (c == 3) ? v.rdata : 32'h0;
            if (c == 1) begin
                chk($sformatf("v%0d_write", vi), {31'b0, write}, 32'h1);
                chk($sformatf("v%0d_rdata_out", vi), resp_data, 32'h0);
            end
            if (c == 2) chk($sformatf("v%0d_read", vi), {31'b0, read}, {31'b0, RB});
            if (gnt != '0) begin
                chk($sformatf("v%0d_gnt_cyc", vi), c, 1);
                if (sb.size() == 0) miss($sformatf("v%0d_sb_gnt", vi));
                else begin
                    chk($sformatf("v%0d_gnt", vi), gnt, sb[0].gnt);
                    chk($sformatf("v%0d_wdata", vi), write_data, sb[0].word);
                end
                req = '0;
            end
            if (done != '0) begin
                got = 1'b1;
                chk($sformatf("v%0d_done_cyc", vi), c, DLAT);
                if (sb.size() == 0) miss($sformatf("v%0d_sb_done", vi));
                else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_done", vi), done, e.gnt);
                    chk($sformatf("v%0d_err", vi), {31'b0, resp_err}, {31'b0, e.err});
                    chk($sformatf("v%0d_data", vi), resp_data, e.data);
                end
            end
        end
        if (!got) begin
            miss($sformatf("v%0d_done_timeout", vi));
            sb.delete();
        end
        req = '0;
        error = 1'b0;
        read_data = '0;
    endtask

    initial begin
        gexp_t g;
        int    dc;
        logic [N-1:0] dv;

        rst = 1'b1; req = '0; req_data = '0; error = 1'b0; read_data = '0;
        vt[0] = '{4'b0001, 1'b0, 32'h0000_0021, 0};
        vt[1] = '{4'b0101, 1'b1, 32'h0000_0055, 2};
        vt[2] = '{4'b0011, 1'b0, 32'h0000_1234, 0};
        vt[3] = '{4'b0011, 1'b0, 32'hDEAD_BEEF, 1};
        vt[4] = '{4'b1000, 1'b0, 32'h0000_0003, 3};
        vt[5] = '{4'b1110, 1'b0, 32'h8000_0001, 1};
        vt[6] = '{4'b1011, 1'b0, 32'h0F0F_0F0F, 3};
        vt[7] = '{4'b0011, 1'b0, 32'h0000_0007, 0};
        vt[8] = '{4'b0011, 1'b0, 32'h1111_2222, 1};
        vt[9] = '{4'b0100, 1'b1, 32'hFFFF_FFFF, 2};

        repeat (2) @(negedge clk);
        chk("reset_ctl", {20'b0, gnt, done, busy, write, read, resp_err}, 32'h0);
        chk("reset_wdata", write_data, 32'h0);
        chk("reset_rdata", resp_data, 32'h0);

        // Rotation with every requester held high.
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            g.cyc = 1 + k * PER;
            g.g = '0;
            g.g[k % N] = 1'b1;
            gq.push_back(g);
        end
        req = '1;
        for (int i = 0; i < N; i++) req_data[i] = wd(99, i);
        for (int c = 1; c <= 1 + 4 * PER; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                if (gq.size() == 0) miss("rot_extra_gnt");
                else begin
                    g = gq.pop_front();
                    chk($sformatf("rot_cyc%0d", g.cyc), c, g.cyc);
                    chk($sformatf("rot_gnt%0d", g.cyc), gnt, g.g);
                end
            end
        end
        req = '0;
        chk("rot_left", gq.size(), 0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_after_rot", {20'b0, gnt, done, busy, write, read, resp_err}, 32'h0);
        rst = 1'b0;

        for (int vi = 0; vi < 10; vi++) run_vec(vi);

        // Reset in the second transaction state; ptr is 3 here, reset must clear it.
        @(negedge clk);
        req = 4'b1100;
        for (int i = 0; i < N; i++) req_data[i] = wd(50, i);
        @(negedge clk);
        chk("mid_gnt0", gnt, 4'b1000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {20'b0, gnt, done, busy, write, read, resp_err}, 32'h0);
        chk("mid_rst_wdata", write_data, 32'h0);
        chk("mid_rst_rdata", resp_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_regnt", gnt, 4'b0100);
        chk("mid_regnt_wdata", write_data, wd(50, 2));
        req = 4'b1000;
        dc = -1;
        dv = '0;
        for (int c = 2; c <= DLAT + 1; c++) begin
            @(negedge clk);
            if (done != '0 && dc < 0) begin
                dc = c;
                dv = done;
            end
        end
        chk("mid_done_cyc", dc, DLAT);
        chk("mid_done", dv, 4'b0100);
        @(negedge clk);
        chk("mid_next_gnt", gnt, 4'b1000);
        req = '0;
        repeat (DLAT + 2) @(negedge clk);
        chk("final_idle", {31'b0, busy}, 32'h0);
        chk("read_seen", {31'b0, (rd_cnt != 0)}, {31'b0, RB});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
